mem_bus_arbiter: RTL and testbench
==================================

# mem_bus_arbiter

Two-port arbiter sitting directly upstream of the single-port 64K×8 system memory: it merges CPU (6502) and DMA (MARIA display-list fetch) requests onto one memory bus. The memory samples address/write at posedge and returns read data one cycle later, holding its output on write cycles. The arbiter grants one requester per cycle, tracks which requester owns the outstanding read, and steers the returned byte back with a valid strobe. DMA has priority, bounded by an anti-starvation counter that guarantees CPU progress.

## Interface
- ADDR_W, 16, address width
- DATA_W, 8, data width
- MAX_DMA_RUN, 4, consecutive DMA grants allowed while CPU is waiting (≥1)
- clk  in  1  system clock; all state on posedge
- rst_b  in  1  reset, asynchronous, active-low
- cpu_req / dma_req  in  1  access request, held until acked
- cpu_we / dma_we  in  1  1 = write, 0 = read; stable while req high
- cpu_addr / dma_addr  in  ADDR_W  access address
- cpu_wdata / dma_wdata  in  DATA_W  write data
- cpu_ack / dma_ack  out  1  grant this cycle (combinational)
- cpu_rvalid / dma_rvalid  out  1  read data valid (registered)
- cpu_rdata / dma_rdata  out  DATA_W  read data, meaningful only with rvalid
- mem_addr  out  ADDR_W  to memory addr
- mem_data_in  out  DATA_W  to memory data_in
- mem_we  out  1  to memory we
- mem_data_out  in  DATA_W  from memory data_out

## Operation
- Grant per cycle: exactly one of cpu_ack/dma_ack or neither; a requester is acked only if its req is high.
- Priority: DMA wins unless run_cnt == MAX_DMA_RUN and cpu_req high, then CPU wins.
- run_cnt (0..MAX_DMA_RUN): +1 on DMA grant while cpu_req high (saturating); cleared on any CPU grant or any cycle with cpu_req low.
- Bus mux: mem_addr/mem_data_in/mem_we from granted requester; no grant → mem_we = 0, mem_addr = 0, mem_data_in = 0.
- Read tag: on a read grant, rd_owner ← CPU/DMA; otherwise rd_owner ← NONE. Cycle after: rvalid of rd_owner = 1, rdata = mem_data_out.
- rdata ports are both driven from mem_data_out; only rvalid is steered.
- Writes produce no rvalid. Back-to-back reads fully pipelined: one read per cycle, any mix of owners.
- Reset values: run_cnt = 0, rd_owner = NONE, cpu_rvalid = dma_rvalid = 0; while rst_b low, acks = 0 and mem_we = 0.
- Reset mid-operation: a read granted in the cycle reset asserts returns no rvalid; no request is remembered across reset.

## Timing
- Ack latency 0: ack in same cycle req is seen (if granted); requester may change address/drop req after that posedge.
- Read latency 1: rvalid/rdata exactly one cycle after ack.
- Worst-case CPU wait with DMA continuously requesting: MAX_DMA_RUN cycles, CPU granted on cycle MAX_DMA_RUN+1.
- Simultaneous req, run_cnt < MAX_DMA_RUN: DMA acked, CPU waits, its req/addr held.
- Write then read same address on consecutive cycles: read returns new data (memory ordering preserved, no bypass needed).

## Structure
- Package mem_bus_pkg: ADDR_W/DATA_W constants, typedef enum logic [1:0] owner_e {OWN_NONE, OWN_CPU, OWN_DMA}, struct mem_req_t {we, addr, wdata}.
- One sub-module natural: mem_arb_grant (priority + run_cnt, outputs owner_e grant); top handles mux and read tag.

## Test plan
- Single CPU write 0x1234←0xA5, then CPU read 0x1234 → cpu_ack each cycle, cpu_rvalid one cycle after read ack with cpu_rdata = 0xA5, dma_rvalid stays 0.
- Simultaneous CPU read 0x0010 and DMA read 0x0020 → dma_ack first, cpu_ack next cycle; rvalids appear in that order with correct data.
- DMA requests continuously, CPU requests from cycle 0, MAX_DMA_RUN = 4 → 4 DMA acks, CPU acked on 5th cycle, run_cnt back to 0, DMA resumes.
- Alternating CPU/DMA reads on 6 consecutive cycles → 6 rvalid pulses, each on the correct port, no bubbles.
- Assert rst_b low in the cycle after a CPU read ack → cpu_rvalid 0 immediately, acks and mem_we 0 during reset, run_cnt = 0 after release.
- No requests for 10 cycles → mem_we = 0, mem_addr = 0, both rvalid = 0 throughout.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// Shared types for the CPU/DMA system-memory arbiter.
// Bus widths, requester identity and the per-requester bus bundle.
package mem_bus_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DMA  = 2'd2
  } owner_e;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

  // Selects the bus bundle of the granted requester; an idle bus is all zero.
  function automatic mem_req_t pick_req(input owner_e grant,
                                        input mem_req_t cpu,
                                        input mem_req_t dma);
    mem_req_t sel;
    case (grant)
      OWN_CPU: sel = cpu;
      OWN_DMA: sel = dma;
      default: sel = '0;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/mem_arb_grant.sv
// Per-cycle grant decision: DMA has priority, but a run counter forces a CPU
// grant after MAX_DMA_RUN consecutive DMA grants while the CPU is waiting.
module mem_arb_grant
  import mem_bus_pkg::*;
#(
  parameter int MAX_DMA_RUN = 4
) (
  input  logic   clk,
  input  logic   rst_b,
  input  logic   cpu_req,
  input  logic   dma_req,
  output owner_e grant
);

  localparam int CNT_W = $clog2(MAX_DMA_RUN + 1);
  localparam logic [CNT_W-1:0] RUN_MAX = CNT_W'(MAX_DMA_RUN);

  logic [CNT_W-1:0] run_cnt;
  logic [CNT_W-1:0] run_cnt_nxt;
  logic             run_sat;

  assign run_sat = (run_cnt == RUN_MAX);

  // Grant selection; nothing is granted while reset is held.
  always_comb begin
    grant = OWN_NONE;
    if (!rst_b) begin
      grant = OWN_NONE;
    end else if (dma_req && !(cpu_req && run_sat)) begin
      grant = OWN_DMA;
    end else if (cpu_req) begin
      grant = OWN_CPU;
    end else begin
      grant = OWN_NONE;
    end
  end

  // Count DMA grants only while the CPU is kept waiting; anything else clears.
  always_comb begin
    run_cnt_nxt = {CNT_W{1'b0}};
    if ((grant == OWN_DMA) && cpu_req) begin
      if (run_sat) begin
        run_cnt_nxt = run_cnt;
      end else begin
        run_cnt_nxt = run_cnt + CNT_W'(1);
      end
    end else begin
      run_cnt_nxt = {CNT_W{1'b0}};
    end
  end

  // Run counter register.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      run_cnt <= {CNT_W{1'b0}};
    end else begin
      run_cnt <= run_cnt_nxt;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Merges CPU and DMA requests onto the single-port system memory and steers
// the one-cycle-late read data back to whichever requester issued the read.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int MAX_DMA_RUN = 4
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              cpu_ack,
  output logic              dma_ack,
  output logic              cpu_rvalid,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic [DATA_W-1:0] dma_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_data_out
);

  owner_e   grant;
  owner_e   rd_owner;
  owner_e   rd_owner_nxt;
  mem_req_t cpu_bus;
  mem_req_t dma_bus;
  mem_req_t mem_bus;

  mem_arb_grant #(
    .MAX_DMA_RUN (MAX_DMA_RUN)
  ) u_grant (
    .clk     (clk),
    .rst_b   (rst_b),
    .cpu_req (cpu_req),
    .dma_req (dma_req),
    .grant   (grant)
  );

  // Memory bus mux and acknowledge decode from the current grant.
  always_comb begin
    cpu_bus     = '{we: cpu_we, addr: cpu_addr, wdata: cpu_wdata};
    dma_bus     = '{we: dma_we, addr: dma_addr, wdata: dma_wdata};
    mem_bus     = pick_req(grant, cpu_bus, dma_bus);
    mem_we      = mem_bus.we;
    mem_addr    = mem_bus.addr;
    mem_data_in = mem_bus.wdata;
    cpu_ack     = (grant == OWN_CPU);
    dma_ack     = (grant == OWN_DMA);
  end

  // Tag the owner of a read granted this cycle; writes leave no tag.
  always_comb begin
    rd_owner_nxt = OWN_NONE;
    case (grant)
      OWN_CPU: begin
        if (cpu_we) begin
          rd_owner_nxt = OWN_NONE;
        end else begin
          rd_owner_nxt = OWN_CPU;
        end
      end
      OWN_DMA: begin
        if (dma_we) begin
          rd_owner_nxt = OWN_NONE;
        end else begin
          rd_owner_nxt = OWN_DMA;
        end
      end
      default: rd_owner_nxt = OWN_NONE;
    endcase
  end

  // Read owner register, aligned with the memory's one-cycle read latency.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      rd_owner <= OWN_NONE;
    end else begin
      rd_owner <= rd_owner_nxt;
    end
  end

  // Only the valid strobes are steered; both data ports see the memory output.
  assign cpu_rvalid = (rd_owner == OWN_CPU);
  assign dma_rvalid = (rd_owner == OWN_DMA);
  assign cpu_rdata  = mem_data_out;
  assign dma_rdata  = mem_data_out;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with a behavioural 64Kx8 memory whose
// unwritten contents are addr[7:0] ^ addr[15:8].
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        cpu_req, cpu_we, dma_req, dma_we;
  logic [15:0] cpu_addr, dma_addr;
  logic [7:0]  cpu_wdata, dma_wdata;
  logic        cpu_ack, dma_ack, cpu_rvalid, dma_rvalid;
  logic [7:0]  cpu_rdata, dma_rdata;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data_in;
  logic        mem_we;
  logic [7:0]  mem_data_out = 8'h00;

  logic [7:0]  mem [0:65535];

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic        creq;
    logic        cwe;
    logic [15:0] caddr;
    logic [7:0]  cwd;
    logic        dreq;
    logic        dwe;
    logic [15:0] daddr;
    logic [7:0]  dwd;
    logic        e_cack;
    logic        e_dack;
    logic        e_we;
    logic [15:0] e_addr;
    logic [7:0]  e_din;
    logic        e_crv;
    logic        e_drv;
    logic [7:0]  e_rdata;
  } vec_t;

  vec_t vecs [0:12];

  mem_bus_arbiter #(.MAX_DMA_RUN(4)) dut (
    .clk          (clk),
    .rst_b        (rst_b),
    .cpu_req      (cpu_req),
    .cpu_we       (cpu_we),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .dma_req      (dma_req),
    .dma_we       (dma_we),
    .dma_addr     (dma_addr),
    .dma_wdata    (dma_wdata),
    .cpu_ack      (cpu_ack),
    .dma_ack      (dma_ack),
    .cpu_rvalid   (cpu_rvalid),
    .dma_rvalid   (dma_rvalid),
    .cpu_rdata    (cpu_rdata),
    .dma_rdata    (dma_rdata),
    .mem_addr     (mem_addr),
    .mem_data_in  (mem_data_in),
    .mem_we       (mem_we),
    .mem_data_out (mem_data_out)
  );

  always #5 clk = ~clk;

  // Memory model: samples at posedge, read data next cycle, output held on writes.
  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = i[7:0] ^ i[15:8];
    forever begin
      @(posedge clk);
      if (mem_we) mem[mem_addr] = mem_data_in;
      else mem_data_out <= mem[mem_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic creq, input logic cwe, input logic [15:0] caddr,
                       input logic [7:0] cwd, input logic dreq, input logic dwe,
                       input logic [15:0] daddr, input logic [7:0] dwd);
    cpu_req = creq; cpu_we = cwe; cpu_addr = caddr; cpu_wdata = cwd;
    dma_req = dreq; dma_we = dwe; dma_addr = daddr; dma_wdata = dwd;
  endtask

  // DMA reads 0x0100+k every cycle; CPU reads 0x0055 when its bit is set.
  task automatic run_pattern(input int n, input logic [15:0] creq_bits,
                             input logic [15:0] expc_bits);
    for (int k = 0; k < n; k++) begin
      drive(creq_bits[k], 1'b0, 16'h0055, 8'h00, 1'b1, 1'b0, 16'h0100 + k[15:0], 8'h00);
      #1;
      chk("pat_cpu_ack", cpu_ack, expc_bits[k]);
      chk("pat_dma_ack", dma_ack, !expc_bits[k]);
      @(posedge clk); #1;
      chk("pat_cpu_rvalid", cpu_rvalid, expc_bits[k]);
      chk("pat_dma_rvalid", dma_rvalid, !expc_bits[k]);
      if (expc_bits[k]) chk("pat_cpu_rdata", cpu_rdata, 8'h55);
      else chk("pat_dma_rdata", dma_rdata, 8'h01 ^ k[7:0]);
      @(negedge clk);
    end
  endtask

  initial begin
    vecs[0]  = '{1'b1,1'b1,16'h1234,8'hA5, 1'b0,1'b0,16'h0000,8'h00, 1'b1,1'b0,1'b1,16'h1234,8'hA5, 1'b0,1'b0,8'h00};
    vecs[1]  = '{1'b1,1'b0,16'h1234,8'h00, 1'b0,1'b0,16'h0000,8'h00, 1'b1,1'b0,1'b0,16'h1234,8'h00, 1'b1,1'b0,8'hA5};
    vecs[2]  = '{1'b1,1'b0,16'h0010,8'h00, 1'b1,1'b0,16'h0020,8'h00, 1'b0,1'b1,1'b0,16'h0020,8'h00, 1'b0,1'b1,8'h20};
    vecs[3]  = '{1'b1,1'b0,16'h0010,8'h77, 1'b0,1'b0,16'h0000,8'h00, 1'b1,1'b0,1'b0,16'h0010,8'h77, 1'b1,1'b0,8'h10};
    vecs[4]  = '{1'b1,1'b0,16'h0041,8'h00, 1'b0,1'b0,16'h0000,8'h00, 1'b1,1'b0,1'b0,16'h0041,8'h00, 1'b1,1'b0,8'h41};
    vecs[5]  = '{1'b0,1'b0,16'h0000,8'h00, 1'b1,1'b0,16'h0052,8'h00, 1'b0,1'b1,1'b0,16'h0052,8'h00, 1'b0,1'b1,8'h52};
    vecs[6]  = '{1'b1,1'b0,16'h0063,8'h00, 1'b0,1'b0,16'h0000,8'h00, 1'b1,1'b0,1'b0,16'h0063,8'h00, 1'b1,1'b0,8'h63};
    vecs[7]  = '{1'b0,1'b0,16'h0000,8'h00, 1'b1,1'b0,16'h0074,8'h00, 1'b0,1'b1,1'b0,16'h0074,8'h00, 1'b0,1'b1,8'h74};
    vecs[8]  = '{1'b1,1'b0,16'h0085,8'h00, 1'b0,1'b0,16'h0000,8'h00, 1'b1,1'b0,1'b0,16'h0085,8'h00, 1'b1,1'b0,8'h85};
    vecs[9]  = '{1'b0,1'b0,16'h0000,8'h00, 1'b1,1'b0,16'h0096,8'h00, 1'b0,1'b1,1'b0,16'h0096,8'h00, 1'b0,1'b1,8'h96};
    vecs[10] = '{1'b0,1'b0,16'h0000,8'h00, 1'b1,1'b1,16'h00AA,8'h3C, 1'b0,1'b1,1'b1,16'h00AA,8'h3C, 1'b0,1'b0,8'h00};
    vecs[11] = '{1'b0,1'b0,16'h0000,8'h00, 1'b1,1'b0,16'h00AA,8'h00, 1'b0,1'b1,1'b0,16'h00AA,8'h00, 1'b0,1'b1,8'h3C};
    vecs[12] = '{1'b0,1'b0,16'h0000,8'h00, 1'b0,1'b0,16'h0000,8'h00, 1'b0,1'b0,1'b0,16'h0000,8'h00, 1'b0,1'b0,8'h00};

    // Reset with requests pending: nothing granted, nothing written.
    rst_b = 1'b0;
    drive(1'b1, 1'b1, 16'h4321, 8'h5A, 1'b1, 1'b1, 16'h8765, 8'hC3);
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_cpu_ack", cpu_ack, 1'b0);
    chk("rst_dma_ack", dma_ack, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_cpu_rvalid", cpu_rvalid, 1'b0);
    chk("rst_dma_rvalid", dma_rvalid, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00);
    rst_b = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 13; v++) begin
      drive(vecs[v].creq, vecs[v].cwe, vecs[v].caddr, vecs[v].cwd,
            vecs[v].dreq, vecs[v].dwe, vecs[v].daddr, vecs[v].dwd);
      #1;
      chk($sformatf("v%0d_cpu_ack", v), cpu_ack, vecs[v].e_cack);
      chk($sformatf("v%0d_dma_ack", v), dma_ack, vecs[v].e_dack);
      chk($sformatf("v%0d_mem_we", v), mem_we, vecs[v].e_we);
      chk($sformatf("v%0d_mem_addr", v), mem_addr, vecs[v].e_addr);
      chk($sformatf("v%0d_mem_data_in", v), mem_data_in, vecs[v].e_din);
      @(posedge clk); #1;
      chk($sformatf("v%0d_cpu_rvalid", v), cpu_rvalid, vecs[v].e_crv);
      chk($sformatf("v%0d_dma_rvalid", v), dma_rvalid, vecs[v].e_drv);
      if (vecs[v].e_crv) chk($sformatf("v%0d_cpu_rdata", v), cpu_rdata, vecs[v].e_rdata);
      if (vecs[v].e_drv) chk($sformatf("v%0d_dma_rdata", v), dma_rdata, vecs[v].e_rdata);
      @(negedge clk);
    end

    // Idle bus for 10 cycles.
    for (int c = 0; c < 10; c++) begin
      drive(1'b0, 1'b0, 16'hFFFF, 8'hFF, 1'b0, 1'b0, 16'hEEEE, 8'hEE);
      #1;
      chk("idle_mem_we", mem_we, 1'b0);
      chk("idle_mem_addr", mem_addr, 16'h0000);
      chk("idle_mem_data_in", mem_data_in, 8'h00);
      @(posedge clk); #1;
      chk("idle_rvalids", {cpu_rvalid, dma_rvalid}, 2'b00);
      @(negedge clk);
    end

    // Starvation bound: 4 DMA then CPU, twice (CPU grant clears the run).
    run_pattern(10, 16'h03FF, 16'h0210);
    // CPU dropping its request for a cycle also clears the run.
    run_pattern(8, 16'h00FB, 16'h0080);

    // Reset one cycle after a CPU read ack kills the pending rvalid at once.
    drive(1'b1, 1'b0, 16'h0012, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00);
    #1;
    chk("rA_cpu_ack", cpu_ack, 1'b1);
    @(posedge clk); #1;
    chk("rA_cpu_rvalid_pre", cpu_rvalid, 1'b1);
    chk("rA_cpu_rdata_pre", cpu_rdata, 8'h12);
    drive(1'b1, 1'b1, 16'h0013, 8'h99, 1'b1, 1'b1, 16'h0014, 8'h88);
    rst_b = 1'b0;
    #1;
    chk("rA_cpu_rvalid_rst", cpu_rvalid, 1'b0);
    chk("rA_acks_rst", {cpu_ack, dma_ack}, 2'b00);
    chk("rA_mem_we_rst", mem_we, 1'b0);
    @(posedge clk); #1;
    chk("rA_rvalids_rst", {cpu_rvalid, dma_rvalid}, 2'b00);
    @(negedge clk);
    drive(1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00);
    rst_b = 1'b1;
    @(negedge clk);

    // Reset mid-run: the run counter restarts and the in-flight grant is dropped.
    run_pattern(3, 16'h0007, 16'h0000);
    drive(1'b1, 1'b0, 16'h0055, 8'h00, 1'b1, 1'b0, 16'h0200, 8'h00);
    #1;
    chk("rB_dma_ack_pre", dma_ack, 1'b1);
    rst_b = 1'b0;
    #1;
    chk("rB_acks_rst", {cpu_ack, dma_ack}, 2'b00);
    @(posedge clk); #1;
    chk("rB_dma_rvalid_rst", dma_rvalid, 1'b0);
    @(negedge clk);
    rst_b = 1'b1;
    run_pattern(5, 16'h001F, 16'h0010);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
